// File: rtl/sseg_scan_decoder.sv
// sseg_scan_decoder: recovers the four hex digits shown on a multiplexed,
// active-low seven-segment display by watching its anode and cathode lines.
// A digit is captured once its anode/segment pair has been stable for
// SETTLE_CYCLES cycles. Completed scans are counted, multi-anode drive is
// flagged, and a stale flag is raised when captures stop arriving.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   seg_an[3:0]  digit anodes, active-low, bit 3 = leftmost digit
//   seg[7:0]     cathodes, active-low, [6:0] = segments g..a, [7] = DP
//   digit_val    decoded hex value, nibble n = digit n
//   digit_dp     captured DP per digit (1 = lit)
//   digit_valid  last capture for the digit was a hex glyph
//   digit_blank  last capture for the digit had segments a..g all off
//   frame_done   one-cycle pulse when all four digits have been captured
//   frame_count  number of frame_done pulses since reset (wraps)
//   err_multi    sticky: more than one anode was seen active
//   stale        no capture for TIMEOUT_CYCLES cycles
module sseg_scan_decoder #(
  parameter int unsigned SETTLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 100_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  seg_an,
  input  logic [7:0]  seg,
  output logic [15:0] digit_val,
  output logic [3:0]  digit_dp,
  output logic [3:0]  digit_valid,
  output logic [3:0]  digit_blank,
  output logic        frame_done,
  output logic [15:0] frame_count,
  output logic        err_multi,
  output logic        stale
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

  state_t            state_q, state_d;
  logic [3:0]        an_r;
  logic [7:0]        seg_r;
  logic [1:0]        idx_q;
  logic [7:0]        pat_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [3:0]        mask_q;
  logic [TO_W-1:0]   tcnt_q;

  logic              one_hot;
  logic [1:0]        an_idx;
  logic              none_low;
  logic              multi_low;
  logic              match;
  logic              settled;
  logic              latch_c;
  logic              incr_c;
  logic              capture_c;
  logic [4:0]        dec;
  logic [3:0]        mask_next;

  // Active-high segment set (g..a) to {valid, nibble}
  function automatic logic [4:0] decode(input logic [6:0] on);
    unique case (on)
      7'h3F:   decode = 5'h10;
      7'h06:   decode = 5'h11;
      7'h5B:   decode = 5'h12;
      7'h4F:   decode = 5'h13;
      7'h66:   decode = 5'h14;
      7'h6D:   decode = 5'h15;
      7'h7D:   decode = 5'h16;
      7'h07:   decode = 5'h17;
      7'h7F:   decode = 5'h18;
      7'h6F:   decode = 5'h19;
      7'h77:   decode = 5'h1A;
      7'h7C:   decode = 5'h1B;
      7'h39:   decode = 5'h1C;
      7'h5E:   decode = 5'h1D;
      7'h79:   decode = 5'h1E;
      7'h71:   decode = 5'h1F;
      default: decode = 5'h00;
    endcase
  endfunction

  // Classify the registered anodes: exactly one low, none low, or several
  always_comb begin
    one_hot = 1'b0;
    an_idx  = 2'd0;
    unique case (an_r)
      4'b1110: begin one_hot = 1'b1; an_idx = 2'd0; end
      4'b1101: begin one_hot = 1'b1; an_idx = 2'd1; end
      4'b1011: begin one_hot = 1'b1; an_idx = 2'd2; end
      4'b0111: begin one_hot = 1'b1; an_idx = 2'd3; end
      default: ;
    endcase
  end

  assign none_low  = (an_r == 4'hF);
  assign multi_low = !one_hot && !none_low;
  assign match     = one_hot && (an_idx == idx_q) && (seg_r == pat_q);
  assign settled   = (cnt_q == CNT_W'(SETTLE_CYCLES));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state; a mismatch falls back through IDLE within the same cycle so
  // a new single-anode pattern starts settling without a lost cycle
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (one_hot) state_d = SETTLE;
      SETTLE:  if (!match)      state_d = one_hot ? SETTLE : IDLE;
               else if (settled) state_d = HOLD;
      HOLD:    if (!match)      state_d = one_hot ? SETTLE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath strobes derived from the current state
  always_comb begin
    latch_c   = 1'b0;
    incr_c    = 1'b0;
    capture_c = 1'b0;
    unique case (state_q)
      IDLE:    latch_c = one_hot;
      SETTLE: begin
        latch_c   = one_hot && !match;
        incr_c    = match && !settled;
        capture_c = match && settled;
      end
      HOLD:    latch_c = one_hot && !match;
      default: ;
    endcase
  end

  assign dec       = decode(~pat_q[6:0]);
  assign mask_next = mask_q | (4'b0001 << idx_q);

  // Input registers, latch/settle tracking, capture, framing and timeout
  always_ff @(posedge clk) begin
    if (rst) begin
      an_r        <= 4'hF;
      seg_r       <= 8'hFF;
      idx_q       <= 2'd0;
      pat_q       <= 8'hFF;
      cnt_q       <= '0;
      mask_q      <= 4'h0;
      tcnt_q      <= '0;
      digit_val   <= 16'h0000;
      digit_dp    <= 4'h0;
      digit_valid <= 4'h0;
      digit_blank <= 4'h0;
      frame_done  <= 1'b0;
      frame_count <= 16'h0000;
      err_multi   <= 1'b0;
      stale       <= 1'b0;
    end else begin
      an_r       <= seg_an;
      seg_r      <= seg;
      frame_done <= 1'b0;

      if (latch_c) begin
        idx_q <= an_idx;
        pat_q <= seg_r;
        cnt_q <= CNT_W'(1);
      end else if (incr_c) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end

      if (multi_low) err_multi <= 1'b1;

      if (capture_c) begin
        digit_val[{idx_q, 2'b00} +: 4] <= dec[3:0];
        digit_valid[idx_q]             <= dec[4];
        digit_blank[idx_q]             <= (pat_q[6:0] == 7'h7F);
        digit_dp[idx_q]                <= ~pat_q[7];
        if (mask_next == 4'hF) begin
          mask_q      <= 4'h0;
          frame_done  <= 1'b1;
          frame_count <= frame_count + 16'd1;
        end else begin
          mask_q <= mask_next;
        end
        tcnt_q <= '0;
        stale  <= 1'b0;
      end else if (tcnt_q != TO_W'(TIMEOUT_CYCLES)) begin
        tcnt_q <= tcnt_q + TO_W'(1);
        stale  <= ((tcnt_q + TO_W'(1)) == TO_W'(TIMEOUT_CYCLES));
      end
    end
  end

endmodule

// File: tb/tb_sseg_scan_decoder.sv
// Directed bench for sseg_scan_decoder (SETTLE_CYCLES=4, TIMEOUT_CYCLES=50).
module tb_sseg_scan_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  seg_an;
  logic [7:0]  seg;
  logic [15:0] digit_val;
  logic [3:0]  digit_dp;
  logic [3:0]  digit_valid;
  logic [3:0]  digit_blank;
  logic        frame_done;
  logic [15:0] frame_count;
  logic        err_multi;
  logic        stale;

  int n_checks = 0;
  int n_fail   = 0;
  int pulses   = 0;

  typedef struct {
    logic [3:0] an;
    logic [7:0] seg;
    logic [1:0] idx;
    logic [3:0] nib;
    logic       dp;
    logic       valid;
    logic       blank;
  } vec_t;

  vec_t        vt[20];
  logic [15:0] exp_val;

  sseg_scan_decoder #(.SETTLE_CYCLES(4), .TIMEOUT_CYCLES(50)) dut (
    .clk(clk), .rst(rst), .seg_an(seg_an), .seg(seg),
    .digit_val(digit_val), .digit_dp(digit_dp), .digit_valid(digit_valid),
    .digit_blank(digit_blank), .frame_done(frame_done),
    .frame_count(frame_count), .err_multi(err_multi), .stale(stale)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance n cycles, sampling 1 time unit after each rising edge
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (frame_done) pulses++;
    end
  endtask

  task automatic drive(input logic [3:0] an, input logic [7:0] s, input int n);
    seg_an = an;
    seg    = s;
    step(n);
  endtask

  initial begin
    // idx-tagged vectors: {an, seg, idx, nib, dp, valid, blank}
    vt[0]  = '{4'hD, 8'hFF, 2'd1, 4'h0, 1'b0, 1'b0, 1'b1};
    vt[1]  = '{4'hB, 8'hFE, 2'd2, 4'h0, 1'b0, 1'b0, 1'b0};
    vt[2]  = '{4'hE, 8'h7F, 2'd0, 4'h0, 1'b1, 1'b0, 1'b1};
    vt[3]  = '{4'h7, 8'h3E, 2'd3, 4'h0, 1'b1, 1'b0, 1'b0};
    vt[4]  = '{4'hE, 8'hC0, 2'd0, 4'h0, 1'b0, 1'b1, 1'b0};
    vt[5]  = '{4'hD, 8'hF9, 2'd1, 4'h1, 1'b0, 1'b1, 1'b0};
    vt[6]  = '{4'hB, 8'hA4, 2'd2, 4'h2, 1'b0, 1'b1, 1'b0};
    vt[7]  = '{4'h7, 8'hB0, 2'd3, 4'h3, 1'b0, 1'b1, 1'b0};
    vt[8]  = '{4'hE, 8'h99, 2'd0, 4'h4, 1'b0, 1'b1, 1'b0};
    vt[9]  = '{4'hD, 8'h92, 2'd1, 4'h5, 1'b0, 1'b1, 1'b0};
    vt[10] = '{4'hB, 8'h82, 2'd2, 4'h6, 1'b0, 1'b1, 1'b0};
    vt[11] = '{4'h7, 8'hF8, 2'd3, 4'h7, 1'b0, 1'b1, 1'b0};
    vt[12] = '{4'hE, 8'h00, 2'd0, 4'h8, 1'b1, 1'b1, 1'b0};
    vt[13] = '{4'hD, 8'h90, 2'd1, 4'h9, 1'b0, 1'b1, 1'b0};
    vt[14] = '{4'hB, 8'h88, 2'd2, 4'hA, 1'b0, 1'b1, 1'b0};
    vt[15] = '{4'h7, 8'h83, 2'd3, 4'hB, 1'b0, 1'b1, 1'b0};
    vt[16] = '{4'hE, 8'hC6, 2'd0, 4'hC, 1'b0, 1'b1, 1'b0};
    vt[17] = '{4'hD, 8'hA1, 2'd1, 4'hD, 1'b0, 1'b1, 1'b0};
    vt[18] = '{4'hB, 8'h06, 2'd2, 4'hE, 1'b1, 1'b1, 1'b0};
    vt[19] = '{4'h7, 8'h8E, 2'd3, 4'hF, 1'b0, 1'b1, 1'b0};

    // Reset
    rst    = 1'b1;
    seg_an = 4'hF;
    seg    = 8'hFF;
    step(3);
    check("reset digit_val",   32'(digit_val),   32'h0);
    check("reset frame_count", 32'(frame_count), 32'h0);
    check("reset stale",       32'(stale),       32'h0);
    check("reset err_multi",   32'(err_multi),   32'h0);

    // Stale: all anodes off after release
    rst = 1'b0;
    step(49);
    check("stale before 50", 32'(stale), 32'h0);
    step(1);
    check("stale at 50", 32'(stale), 32'h1);
    step(10);
    check("stale at 60", 32'(stale), 32'h1);
    check("idle no error", 32'(err_multi), 32'h0);
    check("idle no capture", 32'(digit_val), 32'h0);

    // Scan "0123" with latency and stale-clear timing on the first digit
    pulses = 0;
    drive(4'hE, 8'hB0, 5);
    check("latency N+1 no update", 32'(digit_val), 32'h0);
    check("stale before capture", 32'(stale), 32'h1);
    step(1);
    check("latency N+2 update", 32'(digit_val), 32'h0003);
    check("stale cleared", 32'(stale), 32'h0);
    step(14);
    drive(4'hD, 8'hA4, 20);
    drive(4'hB, 8'hF9, 20);
    drive(4'h7, 8'hC0, 20);
    check("scan digit_val",   32'(digit_val),   32'h0123);
    check("scan digit_valid", 32'(digit_valid), 32'hF);
    check("scan pulses",      32'(pulses),      32'd1);
    check("scan frame_count", 32'(frame_count), 32'd1);

    // Glitch: seg[2] toggles every 3 cycles, then settles on "5"
    begin
      logic [7:0] s;
      s = 8'h92;
      for (int k = 0; k < 8; k++) begin
        drive(4'hE, s, 3);
        s = s ^ 8'h04;
      end
    end
    check("glitch no capture", 32'(digit_val), 32'h0123);
    drive(4'hE, 8'h92, 5);
    check("glitch settle 5 cycles", 32'(digit_val), 32'h0123);
    step(1);
    check("glitch settle 6 cycles", 32'(digit_val), 32'h0125);

    // Table of decode vectors
    exp_val = 16'h0125;
    for (int i = 0; i < 20; i++) begin
      drive(vt[i].an, vt[i].seg, 8);
      exp_val[{vt[i].idx, 2'b00} +: 4] = vt[i].nib;
      check($sformatf("vec%0d nibble", i), 32'(digit_val[{vt[i].idx, 2'b00} +: 4]), 32'(vt[i].nib));
      check($sformatf("vec%0d dp", i),     32'(digit_dp[vt[i].idx]),    32'(vt[i].dp));
      check($sformatf("vec%0d valid", i),  32'(digit_valid[vt[i].idx]), 32'(vt[i].valid));
      check($sformatf("vec%0d blank", i),  32'(digit_blank[vt[i].idx]), 32'(vt[i].blank));
    end
    check("table digit_val", 32'(digit_val), 32'(exp_val));

    // Multiple anodes: sticky error, no capture
    drive(4'hC, 8'hF9, 10);
    check("multi err_multi", 32'(err_multi), 32'h1);
    check("multi no capture", 32'(digit_val), 32'hFEDC);
    drive(4'hE, 8'hF9, 10);
    check("err_multi sticky", 32'(err_multi), 32'h1);
    check("resume capture", 32'(digit_val), 32'hFED1);

    // Reset mid-settle, then a full settle is needed afterwards
    drive(4'hD, 8'hA4, 3);
    rst = 1'b1;
    step(1);
    check("mid reset digit_val",   32'(digit_val),   32'h0);
    check("mid reset digit_dp",    32'(digit_dp),    32'h0);
    check("mid reset digit_valid", 32'(digit_valid), 32'h0);
    check("mid reset digit_blank", 32'(digit_blank), 32'h0);
    check("mid reset frame_done",  32'(frame_done),  32'h0);
    check("mid reset frame_count", 32'(frame_count), 32'h0);
    check("mid reset err_multi",   32'(err_multi),   32'h0);
    check("mid reset stale",       32'(stale),       32'h0);
    rst = 1'b0;
    step(5);
    check("post reset no early capture", 32'(digit_val), 32'h0);
    step(1);
    check("post reset full settle", 32'(digit_val), 32'h0020);

    // Re-capturing digit 1 must not complete a frame early
    pulses = 0;
    drive(4'hD, 8'h92, 8);
    drive(4'hE, 8'hF9, 8);
    drive(4'hB, 8'hB0, 8);
    check("recapture no frame", 32'(pulses), 32'd0);
    check("recapture frame_count", 32'(frame_count), 32'd0);
    drive(4'h7, 8'hF8, 8);
    check("frame after 4 digits", 32'(pulses), 32'd1);
    check("frame_count one", 32'(frame_count), 32'd1);
    check("frame digit_val", 32'(digit_val), 32'h7351);

    // frame_count wrap
    force dut.frame_count = 16'hFFFF;
    step(1);
    release dut.frame_count;
    pulses = 0;
    drive(4'hE, 8'h80, 8);
    drive(4'hD, 8'hF9, 8);
    drive(4'hB, 8'hA4, 8);
    drive(4'h7, 8'hB0, 8);
    check("wrap pulse", 32'(pulses), 32'd1);
    check("wrap frame_count", 32'(frame_count), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sseg_scan_decoder.md
SSEG_SCAN_DECODER -- requirements
Module: sseg_scan_decoder

Interface
REQ-001 The block SHALL have parameter SETTLE_CYCLES, default 4, meaning the number of consecutive cycles with identical anode and segment inputs required before a digit is captured (legal range 1..255).
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 100_000, meaning the number of cycles without a capture after which the scan is flagged stale.
REQ-003 clk  input  1  system clock; every register in the block is clocked on its rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 seg_an  input  4  digit anodes, active-low; bit n selects digit n, and digit 3 is the leftmost.
REQ-006 seg  input  8  segment cathodes, active-low; seg[0]..seg[6] are segments a..g, and seg[7] is DP.
REQ-007 digit_val  output  16  decoded hex value; nibble n ([4n+3:4n]) belongs to digit n.
REQ-008 digit_dp  output  4  captured DP state per digit; 1 means lit.
REQ-009 digit_valid  output  4  1 when the last pattern captured for that digit decoded to a hex glyph.
REQ-010 digit_blank  output  4  1 when the last pattern captured for that digit had all segments a..g off.
REQ-011 frame_done  output  1  one-cycle pulse that fires when all four digits have been captured since the previous pulse.
REQ-012 frame_count  output  16  number of frame_done pulses since reset; wraps.
REQ-013 err_multi  output  1  sticky flag set when more than one anode is seen active.
REQ-014 stale  output  1  1 while no capture has occurred for TIMEOUT_CYCLES cycles.

Function
REQ-015 seg_an and seg SHALL be registered once; all further logic SHALL operate on the registered copies.
REQ-016 The state machine SHALL have three states: IDLE, SETTLE and HOLD.
REQ-017 IDLE: when exactly one registered anode is low, the block SHALL latch the anode index and the segment word, load the settle counter with 1, and go to SETTLE.
REQ-018 SETTLE: if the anode and segment inputs equal the latched values, the counter SHALL increment; otherwise the block SHALL return to IDLE in the same cycle.
REQ-019 SETTLE: in the cycle the counter reaches SETTLE_CYCLES, the block SHALL perform a capture (REQ-021) and go to HOLD.
REQ-020 HOLD: the block SHALL stay in HOLD while the inputs equal the latched values; on any change it SHALL go to IDLE. A held digit SHALL be captured only once.
REQ-021 Capture SHALL update the digit_val nibble, digit_dp, digit_valid and digit_blank for the latched index, visible one cycle after the capture cycle.
REQ-021a For SETTLE_CYCLES=N, the total latency from a new stable input to an updated output SHALL be N+2 cycles.
REQ-022 Decode SHALL use the active-high segment sets: 0=abcdef, 1=bc, 2=abdeg, 3=abcdg, 4=bcfg, 5=acdfg, 6=acdefg, 7=abc, 8=abcdefg, 9=abcdfg, A=abcefg, b=cdefg, C=adef, d=bcdeg, E=adefg, F=aefg.
REQ-023 An all-off pattern SHALL set blank=1, valid=0 and nibble=0.
REQ-024 Any pattern not listed in REQ-022 SHALL set valid=0, blank=0 and nibble=0.
REQ-025 DP SHALL be captured independently of the decode result.
REQ-026 A 4-bit capture mask SHALL set the bit for each captured index.
REQ-027 When the mask, including the current capture, equals 4'b1111, the block SHALL:
- pulse frame_done in the output-update cycle;
- increment frame_count, wrapping 0xFFFF->0x0000;
- clear the mask.
REQ-028 Re-capturing an index already set in the mask SHALL NOT count toward frame completion twice.
REQ-029 If two or more registered anodes are low, the block SHALL:
- set err_multi and hold it until reset;
- force the state to IDLE;
- perform no capture.
REQ-030 All anodes high SHALL force the state to IDLE, with no capture and no error.
REQ-031 A timeout counter SHALL clear on every capture and otherwise increment, saturating at TIMEOUT_CYCLES.
REQ-032 stale SHALL be 1 when the timeout counter equals TIMEOUT_CYCLES, and SHALL clear in the cycle after the next capture.

Reset
REQ-033 While rst=1, the block SHALL force:
- state to IDLE;
- the input registers to all-ones (all anodes and segments off);
- digit_val=0, digit_dp=0, digit_valid=0, digit_blank=0;
- frame_done=0, frame_count=0;
- err_multi=0, stale=0;
- the mask, settle counter and timeout counter to 0.
REQ-034 Reset asserted during SETTLE or HOLD SHALL abort the operation with no partial capture; the first capture after reset SHALL require a full settle.

Verification
REQ-035 Scan test: drive seg_an=1110 with the pattern for "3" (seg=8'hB0), then 1101/"2", then 1011/"1", then 0111/"0", each held 20 cycles, SETTLE_CYCLES=4. Required: digit_val=16'h0123, digit_valid=4'hF, exactly one frame_done pulse, frame_count=1.
REQ-036 Glitch test: toggle seg[2] every 3 cycles while seg_an=1110 with SETTLE_CYCLES=4. Required: no capture and digit_val unchanged; after the toggling stops, a capture occurs at exactly 6 cycles.
REQ-037 Blank/invalid test: seg=8'hFF on digit 1 -> digit_blank[1]=1. seg=8'hFE (a only) on digit 2 -> digit_valid[2]=0 and nibble 2=0. seg=8'h7F on digit 0 -> digit_dp[0]=1 and digit_blank[0]=1.
REQ-038 Error test: seg_an=1100 for 10 cycles. Required: err_multi=1 and stays 1 after valid scanning resumes; no capture occurs.
REQ-039 Stale test: TIMEOUT_CYCLES=50, all anodes high for 60 cycles. Required: stale=1 from cycle 50; it clears one cycle after the next capture.
REQ-040 Reset and wrap test:
- assert rst mid-SETTLE -> all outputs are 0;
- preload 65535 frames (or force the counter) and complete one more frame -> frame_count=0 with frame_done pulsed.
